layer_activation_buffer: RTL and testbench

LAYER_ACTIVATION_BUFFER -- requirements
Module: layer_activation_buffer

---
 rtl/layer_activation_buffer.sv | 115 +++++++++++
 tb/tb_layer_activation_buffer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/layer_activation_buffer.sv
// Collects one layer of neuron results, requantizes each to an unsigned
// activation slot, and tracks the index of the largest raw result.
module layer_activation_buffer #(
  parameter int N_NEURONS = 10,
  parameter int WIDTH_IN  = 32,
  parameter int WIDTH_OUT = 8,
  parameter int SHIFT     = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              layer_go,
  input  logic                              in_valid,
  input  logic signed [WIDTH_IN-1:0]        in_data,
  output logic [WIDTH_OUT*N_NEURONS-1:0]    out_data,
  output logic [$clog2(N_NEURONS)-1:0]      max_index,
  output logic                              layer_done,
  output logic                              busy
);

  localparam int CNT_W = $clog2(N_NEURONS);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(N_NEURONS - 1);
  // Largest positive activation, widened so it compares against the shifted input.
  localparam logic signed [WIDTH_IN-1:0] SAT_WIDE =
    {{(WIDTH_IN-WIDTH_OUT+1){1'b0}}, {(WIDTH_OUT-1){1'b1}}};
  localparam logic [WIDTH_OUT-1:0] SAT_Q = {1'b0, {(WIDTH_OUT-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t                      state_reg, state_next;
  logic [CNT_W-1:0]            count_reg;
  logic [CNT_W-1:0]            max_index_reg;
  logic signed [WIDTH_IN-1:0]  max_value_reg;
  logic [WIDTH_OUT-1:0]        slot_reg [N_NEURONS];

  logic                        start;
  logic                        accept;
  logic                        take_max;
  logic signed [WIDTH_IN-1:0]  shifted;
  logic [WIDTH_OUT-1:0]        quant;

  assign start  = (state_reg == IDLE) && layer_go;
  assign accept = (state_reg == COLLECT) && in_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (layer_go) state_next = COLLECT;
      COLLECT: if (in_valid && count_reg == LAST_SLOT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign layer_done = (state_reg == DONE);
  assign busy       = (state_reg == COLLECT);

  // Non-positive inputs (sign bit set or exactly zero) map to zero.
  assign shifted = in_data >>> SHIFT;

  always_comb begin
    quant = '0;
    if (in_data[WIDTH_IN-1] || in_data == '0) begin
      quant = '0;
    end else if (shifted > SAT_WIDE) begin
      quant = SAT_Q;
    end else begin
      quant = shifted[WIDTH_OUT-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || start) begin
      count_reg <= '0;
    end else if (accept) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // First sample always loads; later ones only on strictly greater, so ties keep the lowest index.
  assign take_max = accept && (count_reg == '0 || in_data > max_value_reg);

  always_ff @(posedge clk) begin
    if (reset || start) begin
      max_value_reg <= '0;
      max_index_reg <= '0;
    end else if (take_max) begin
      max_value_reg <= in_data;
      max_index_reg <= count_reg;
    end
  end

  assign max_index = max_index_reg;

  generate
    for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (reset || start) begin
          slot_reg[gi] <= '0;
        end else if (accept && count_reg == CNT_W'(gi)) begin
          slot_reg[gi] <= quant;
        end
      end
      assign out_data[gi*WIDTH_OUT +: WIDTH_OUT] = slot_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_layer_activation_buffer.sv
// Directed bench for layer_activation_buffer at default parameters.
module tb_layer_activation_buffer;
  localparam int N  = 10;
  localparam int WI = 32;
  localparam int WO = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 layer_go;
  logic                 in_valid;
  logic signed [WI-1:0] in_data;
  logic [WO*N-1:0]      out_data;
  logic [3:0]           max_index;
  logic                 layer_done;
  logic                 busy;

  int vectors = 0;
  int miscompares = 0;
  int exp_s[N];
  logic [WO*N-1:0] hold_flat;

  layer_activation_buffer dut (
    .clk(clk), .reset(reset), .layer_go(layer_go), .in_valid(in_valid),
    .in_data(in_data), .out_data(out_data), .max_index(max_index),
    .layer_done(layer_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WO*N-1:0] pack(input int s[N]);
    logic [WO*N-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[k*WO +: WO] = s[k][WO-1:0];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] v, input int gap);
    in_valid = 1'b1;
    in_data  = v;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    repeat (gap) tick();
  endtask

  task automatic go();
    layer_go = 1'b1;
    tick();
    layer_go = 1'b0;
    chk("go_cleared", out_data, '0);
    chk("go_max_cleared", max_index, 4'd0);
    chk("go_busy", busy, 1'b1);
  endtask

  // Reference layer: in_data = 256*k gives slot k = k and max_index 9.
  task automatic ref_layer(input string tag);
    go();
    for (int k = 0; k < N; k++) begin
      send(256 * k, 0);
      if (k == 3) begin
        for (int j = 0; j < N; j++) exp_s[j] = (j <= 3) ? j : 0;
        chk({tag, "_partial"}, out_data, pack(exp_s));
        chk({tag, "_partial_max"}, max_index, 4'd3);
        chk({tag, "_no_early_done"}, layer_done, 1'b0);
      end
    end
    for (int j = 0; j < N; j++) exp_s[j] = j;
    chk({tag, "_done"}, layer_done, 1'b1);
    chk({tag, "_busy_in_done"}, busy, 1'b0);
    chk({tag, "_slots"}, out_data, pack(exp_s));
    chk({tag, "_max"}, max_index, 4'd9);
    tick();
    chk({tag, "_done_single"}, layer_done, 1'b0);
    chk({tag, "_busy_after"}, busy, 1'b0);
    chk({tag, "_hold"}, out_data, pack(exp_s));
  endtask

  initial begin
    reset = 1'b1; layer_go = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) tick();
    chk("rst_out", out_data, '0);
    chk("rst_max", max_index, 4'd0);
    chk("rst_done", layer_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick();

    ref_layer("basic");

    // Back-to-back: layer_go in the first IDLE cycle after DONE.
    go();
    for (int k = 0; k < N; k++) send(2560 - 256 * k, 0);
    for (int j = 0; j < N; j++) exp_s[j] = 10 - j;
    chk("b2b_done", layer_done, 1'b1);
    chk("b2b_slots", out_data, pack(exp_s));
    chk("b2b_max", max_index, 4'd0);
    tick();

    // Requantization boundaries.
    go();
    send(32'hFFFFFFFF, 0); send(0, 0); send(255, 0); send(256, 0);
    send(32767, 0); send(32768, 0); send(32'h7FFFFFFF, 0);
    send(32'h80000000, 0); send(512, 0); send(100, 0);
    exp_s = '{0, 0, 0, 1, 127, 127, 127, 0, 2, 0};
    chk("quant_done", layer_done, 1'b1);
    chk("quant_slots", out_data, pack(exp_s));
    chk("quant_max", max_index, 4'd6);
    tick();

    // All negative: first sample is the largest.
    go();
    for (int k = 0; k < N; k++) send(-5 - k, 0);
    chk("neg_slots", out_data, '0);
    chk("neg_max", max_index, 4'd0);
    tick();

    // All equal: tie keeps index 0.
    go();
    for (int k = 0; k < N; k++) send(1000, 0);
    for (int j = 0; j < N; j++) exp_s[j] = 3;
    chk("tie_slots", out_data, pack(exp_s));
    chk("tie_max", max_index, 4'd0);
    tick();
    hold_flat = pack(exp_s);

    // Stray in_valid in IDLE, and coinciding with layer_go.
    send(5000, 0);
    chk("idle_valid_ignored", out_data, hold_flat);
    chk("idle_valid_busy", busy, 1'b0);
    in_valid = 1'b1; in_data = 99999;
    go();
    in_valid = 1'b0; in_data = '0;
    for (int k = 0; k < N - 1; k++) begin
      send(256 * k, k % 4);
      if (k == 5) begin
        layer_go = 1'b1;
        tick();
        layer_go = 1'b0;
        chk("collect_go_busy", busy, 1'b1);
      end
    end
    // Last sample, then in_valid held high through the DONE cycle.
    in_valid = 1'b1; in_data = 256 * 9;
    tick();
    chk("gap_done", layer_done, 1'b1);
    in_data = 32'h7FFFFFFF;
    tick();
    in_valid = 1'b0; in_data = '0;
    for (int j = 0; j < N; j++) exp_s[j] = j;
    chk("gap_slots", out_data, pack(exp_s));
    chk("gap_max", max_index, 4'd9);
    chk("gap_done_single", layer_done, 1'b0);

    // Reset mid-collection.
    go();
    for (int k = 0; k < 4; k++) send(256 * (k + 1), 0);
    chk("abort_busy_pre", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_out", out_data, '0);
    chk("abort_max", max_index, 4'd0);
    chk("abort_busy", busy, 1'b0);
    for (int c = 0; c < 3; c++) begin
      chk("abort_no_done", layer_done, 1'b0);
      tick();
    end
    // Reset wins over a coincident layer_go.
    reset = 1'b1; layer_go = 1'b1;
    tick();
    reset = 1'b0; layer_go = 1'b0;
    chk("rst_prio_busy", busy, 1'b0);
    tick();
    chk("rst_prio_still_idle", busy, 1'b0);

    ref_layer("after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
